// File: rtl/hog_frame_sequencer.sv
// hog_frame_sequencer: streams one BRAM image frame into hog_top and handshakes completion; HOG_SEQ_TIMEOUT_EN adds a WAIT_DONE watchdog
module hog_frame_sequencer #(
  parameter int          IMAGE_SIZE     = 18495,
  parameter int          ADDR_WIDTH     = 15,
  parameter int          P_WIDTH        = 8,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000
) (
  input  logic                  aclk,
  input  logic                  arest_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout,
  output logic [15:0]           frame_cnt,
  output logic [ADDR_WIDTH-1:0] img_addrb,
  output logic                  img_enb,
  input  logic [P_WIDTH-1:0]    img_doutb,
  input  logic                  hog_ready,
  output logic [P_WIDTH-1:0]    p,
  output logic                  p_valid,
  output logic                  finish,
  input  logic                  write_feature_done
);
  typedef enum logic [2:0] {IDLE, WAIT_READY, STREAM, FLUSH, FINISH, WAIT_DONE} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(IMAGE_SIZE);
  state_t state;
`ifdef HOG_SEQ_TIMEOUT_EN
  logic [23:0] wdog;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign err_timeout = 1'b0;
`endif
  assign busy = state != IDLE;
  assign p = p_valid ? img_doutb : '0;
  // frame sequencer: BRAM read issue, pixel qualifier, end-of-frame handshake
  always_ff @(posedge aclk) begin
    if (!arest_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      finish    <= 1'b0;
      frame_cnt <= '0;
      img_addrb <= '0;
      img_enb   <= 1'b0;
      p_valid   <= 1'b0;
`ifdef HOG_SEQ_TIMEOUT_EN
      err_timeout <= 1'b0;
      wdog        <= '0;
`endif
    end else begin
      done    <= 1'b0;
      finish  <= 1'b0;
      p_valid <= img_enb;
      if (abort) begin
        state   <= IDLE;
        img_enb <= 1'b0;
        p_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state <= WAIT_READY;
`ifdef HOG_SEQ_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
          end
          WAIT_READY: if (hog_ready) begin
            state     <= STREAM;
            img_enb   <= 1'b1;
            img_addrb <= '0;
          end
          STREAM: if (img_addrb == LAST) begin
            state   <= FLUSH;
            img_enb <= 1'b0;
          end else img_addrb <= img_addrb + ADDR_WIDTH'(1);
          FLUSH: begin
            state  <= FINISH;
            finish <= 1'b1;
          end
          FINISH: begin
            state <= WAIT_DONE;
`ifdef HOG_SEQ_TIMEOUT_EN
            wdog <= '0;
`endif
          end
          WAIT_DONE: if (write_feature_done) begin
            state     <= IDLE;
            done      <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
          end
`ifdef HOG_SEQ_TIMEOUT_EN
          else if (wdog == TIMEOUT_CYCLES - 24'd1) begin
            state       <= IDLE;
            err_timeout <= 1'b1;
          end else wdog <= wdog + 24'd1;
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hog_frame_sequencer.sv
// tb_hog_frame_sequencer: randomized directed bench checking frame timing, pixel order, abort, reset and wrap against expected cycle arithmetic
module tb_hog_frame_sequencer;
  localparam int N = 15;
  logic aclk = 0, arest_n = 0, start = 0, abort = 0, hog_ready = 0, write_feature_done = 0;
  logic busy, done, err_timeout, img_enb, p_valid, finish;
  logic [15:0] frame_cnt;
  logic [14:0] img_addrb;
  logic [7:0] img_doutb, p;
  logic [7:0] mem [0:N];
  int cyc = 0, n_cmp = 0, n_err = 0;
  logic [15:0] exp_fc = 16'd0;
  logic [7:0] pix_log [0:1023];
  logic [14:0] addr_log [0:1023];
  int pv_cyc [0:1023];
  int en_cyc [0:1023];
  int pv_n = 0, en_n = 0, fin_n = 0, done_n = 0, fin_cyc = 0, done_cyc = 0;
  hog_frame_sequencer #(.IMAGE_SIZE(N), .ADDR_WIDTH(15), .P_WIDTH(8), .TIMEOUT_CYCLES(24'd100)) dut (
    .aclk(aclk), .arest_n(arest_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .err_timeout(err_timeout), .frame_cnt(frame_cnt), .img_addrb(img_addrb), .img_enb(img_enb),
    .img_doutb(img_doutb), .hog_ready(hog_ready), .p(p), .p_valid(p_valid), .finish(finish),
    .write_feature_done(write_feature_done));
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;
  always @(posedge aclk) if (img_enb) img_doutb <= mem[img_addrb[3:0]];
  always @(negedge aclk) begin
    if (p_valid) begin pix_log[pv_n % 1024] = p; pv_cyc[pv_n % 1024] = cyc; pv_n++; end
    if (img_enb) begin addr_log[en_n % 1024] = img_addrb; en_cyc[en_n % 1024] = cyc; en_n++; end
    if (finish) begin fin_n++; fin_cyc = cyc; end
    if (done) begin done_n++; done_cyc = cyc; end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish observed=timeout expected=finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge aclk); #1;
  endtask
  task automatic launch(input int rdy_dly, output int first);
    int s;
    for (int i = 0; i <= N; i++) mem[i] = 8'($urandom);
    hog_ready = (rdy_dly == 0);
    start = 1; s = cyc; step; start = 0;
    for (int i = 1; i < rdy_dly; i++) begin
      chk("wait_ready_busy", busy === 1'b1, busy, 1'b1);
      chk("wait_ready_no_enb", img_enb === 1'b0, img_enb, 1'b0);
      step;
    end
    hog_ready = 1;
    first = s + 1 + ((rdy_dly > 1) ? rdy_dly : 1);
  endtask
  task automatic check_pixels(input int e0, input int p0, input int first, input int cnt);
    int j, k;
    for (int i = 0; i < cnt; i++) begin
      j = (e0 + i) % 1024; k = (p0 + i) % 1024;
      chk("addr_order", addr_log[j] === 15'(i), addr_log[j], 15'(i));
      chk("enb_cycle", en_cyc[j] === first + i, en_cyc[j], first + i);
      chk("pixel_data", pix_log[k] === mem[i], pix_log[k], mem[i]);
      chk("pvalid_cycle", pv_cyc[k] === first + 1 + i, pv_cyc[k], first + 1 + i);
    end
  endtask
  task automatic wait_finish(input int f0, input bit noise);
    int g = 0;
    while (fin_n == f0 && g < 200) begin
      start = noise && ($urandom_range(3) == 0);
      write_feature_done = noise && ($urandom_range(3) == 0);
      step; g++;
    end
    start = 0; write_feature_done = 0;
  endtask
  task automatic full_frame(input int rdy_dly, input int wfd_dly, input bit noise);
    int e0, p0, f0, d0, first, w;
    e0 = en_n; p0 = pv_n; f0 = fin_n; d0 = done_n;
    launch(rdy_dly, first);
    wait_finish(f0, noise);
    chk("finish_count", fin_n - f0 === 1, fin_n - f0, 1);
    chk("finish_cycle", fin_cyc === first + N + 2, fin_cyc, first + N + 2);
    chk("enb_count", en_n - e0 === N + 1, en_n - e0, N + 1);
    chk("pvalid_count", pv_n - p0 === N + 1, pv_n - p0, N + 1);
    check_pixels(e0, p0, first, N + 1);
    for (int i = 0; i < wfd_dly; i++) begin start = noise && ($urandom_range(2) == 0); step; end
    start = 0;
    chk("wait_done_busy", busy === 1'b1, busy, 1'b1);
    chk("no_early_done", done_n - d0 === 0, done_n - d0, 0);
    write_feature_done = 1; w = cyc; step; write_feature_done = 0;
    exp_fc = exp_fc + 16'd1;
    chk("done_pulse", done === 1'b1, done, 1'b1);
    chk("busy_fall_with_done", busy === 1'b0, busy, 1'b0);
    chk("frame_cnt", frame_cnt === exp_fc, frame_cnt, exp_fc);
    step;
    chk("done_one_cycle", done === 1'b0, done, 1'b0);
    chk("done_count", done_n - d0 === 1, done_n - d0, 1);
    chk("done_cycle", done_cyc === w + 1, done_cyc, w + 1);
    chk("err_timeout_clear", err_timeout === 1'b0, err_timeout, 1'b0);
  endtask
  initial begin
    int e0, p0, f0, d0, first;
    step; step;
    chk("rst_busy", busy === 1'b0, busy, 1'b0);
    chk("rst_done", done === 1'b0, done, 1'b0);
    chk("rst_err", err_timeout === 1'b0, err_timeout, 1'b0);
    chk("rst_frame_cnt", frame_cnt === 16'd0, frame_cnt, 16'd0);
    chk("rst_addr", img_addrb === 15'd0, img_addrb, 15'd0);
    chk("rst_enb", img_enb === 1'b0, img_enb, 1'b0);
    chk("rst_p", p === 8'd0, p, 8'd0);
    chk("rst_pvalid", p_valid === 1'b0, p_valid, 1'b0);
    chk("rst_finish", finish === 1'b0, finish, 1'b0);
    arest_n = 1;
    while (cyc < 10) step;
    full_frame(0, 10, 0);
    chk("nominal_first_enb", en_cyc[0] === 12, en_cyc[0], 12);
    chk("nominal_first_pvalid", pv_cyc[0] === 13, pv_cyc[0], 13);
    chk("nominal_last_pvalid", pv_cyc[N] === 28, pv_cyc[N], 28);
    chk("nominal_finish", fin_cyc === 29, fin_cyc, 29);
    chk("nominal_done", done_cyc === 41, done_cyc, 41);
    full_frame(50, 3, 0);
    e0 = en_n; p0 = pv_n; f0 = fin_n; d0 = done_n;
    launch(0, first);
    while (cyc < first + 8) step;
    abort = 1; step; abort = 0;
    chk("abort_pvalid", p_valid === 1'b0, p_valid, 1'b0);
    chk("abort_enb", img_enb === 1'b0, img_enb, 1'b0);
    chk("abort_busy", busy === 1'b0, busy, 1'b0);
    repeat (5) step;
    chk("abort_pixels", pv_n - p0 === 8, pv_n - p0, 8);
    chk("abort_enables", en_n - e0 === 9, en_n - e0, 9);
    chk("abort_no_finish", fin_n - f0 === 0, fin_n - f0, 0);
    chk("abort_no_done", done_n - d0 === 0, done_n - d0, 0);
    chk("abort_frame_cnt", frame_cnt === exp_fc, frame_cnt, exp_fc);
    check_pixels(e0, p0, first, 8);
    full_frame(0, 2, 0);
    for (int k = 0; k < 3; k++) full_frame($urandom_range(5), $urandom_range(20), 1);
    f0 = fin_n; d0 = done_n;
    launch($urandom_range(3), first);
    wait_finish(f0, 0);
    abort = 1; write_feature_done = 1; start = 1; step;
    abort = 0; write_feature_done = 0; start = 0;
    chk("abort_prio_done", done === 1'b0, done, 1'b0);
    chk("abort_prio_busy", busy === 1'b0, busy, 1'b0);
    step;
    chk("abort_prio_start_ignored", busy === 1'b0, busy, 1'b0);
    chk("abort_prio_done_count", done_n - d0 === 0, done_n - d0, 0);
    chk("abort_prio_frame_cnt", frame_cnt === exp_fc, frame_cnt, exp_fc);
    force dut.frame_cnt = 16'hFFFF;
    step;
    release dut.frame_cnt;
    exp_fc = 16'hFFFF;
    step;
    chk("preload_frame_cnt", frame_cnt === 16'hFFFF, frame_cnt, 16'hFFFF);
    full_frame(0, 1, 0);
    chk("wrap_frame_cnt", frame_cnt === 16'd0, frame_cnt, 16'd0);
    launch(0, first);
    while (cyc < first + 4) step;
    arest_n = 0; step;
    chk("midrst_busy", busy === 1'b0, busy, 1'b0);
    chk("midrst_enb", img_enb === 1'b0, img_enb, 1'b0);
    chk("midrst_pvalid", p_valid === 1'b0, p_valid, 1'b0);
    chk("midrst_p", p === 8'd0, p, 8'd0);
    chk("midrst_addr", img_addrb === 15'd0, img_addrb, 15'd0);
    chk("midrst_frame_cnt", frame_cnt === 16'd0, frame_cnt, 16'd0);
    chk("midrst_finish", finish === 1'b0, finish, 1'b0);
    chk("midrst_done", done === 1'b0, done, 1'b0);
    arest_n = 1; exp_fc = 16'd0;
    step;
    full_frame(1, 4, 1);
`ifdef HOG_SEQ_TIMEOUT_EN
    f0 = fin_n; d0 = done_n;
    launch(0, first);
    wait_finish(f0, 0);
    repeat (99) step;
    chk("timeout_not_yet", err_timeout === 1'b0, err_timeout, 1'b0);
    chk("timeout_still_busy", busy === 1'b1, busy, 1'b1);
    step;
    chk("timeout_flag", err_timeout === 1'b1, err_timeout, 1'b1);
    chk("timeout_idle", busy === 1'b0, busy, 1'b0);
    chk("timeout_no_done", done_n - d0 === 0, done_n - d0, 0);
    chk("timeout_frame_cnt", frame_cnt === exp_fc, frame_cnt, exp_fc);
    start = 1; step; start = 0;
    chk("timeout_cleared_by_start", err_timeout === 1'b0, err_timeout, 1'b0);
    abort = 1; step; abort = 0;
`else
    chk("err_timeout_tied", err_timeout === 1'b0, err_timeout, 1'b0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
